// File: rtl/demux14_pkg.sv
// Shared constants and types for the buffered 1-to-4 demultiplexer.
package demux14_pkg;

  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 16;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t CH0 = 2'd0;
  localparam sel_t CH1 = 2'd1;
  localparam sel_t CH2 = 2'd2;
  localparam sel_t CH3 = 2'd3;

endpackage

// File: rtl/demux14_slot.sv
// One output channel: single-entry data register, full flag and valid/ready handshake.
module demux14_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             o_ready,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  // A load on the same edge as a drain wins, so the channel sustains one beat per cycle.
  always_comb begin
    data_d = data_q;
    full_d = full_q & ~o_ready;
    if (load) begin
      data_d = in_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data = data_q;
  assign full = full_q;

endmodule

// File: rtl/demux14_buf.sv
// Buffered 1-to-4 demux with per-channel holding registers and accepted-beat counter.
// Define DEMUX14_AUTO_SEL_EN to steer beats round-robin instead of by {s1,s0}.
module demux14_buf
  import demux14_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              s0,
  input  logic              s1,
  output logic [WIDTH-1:0]  o0,
  output logic [WIDTH-1:0]  o1,
  output logic [WIDTH-1:0]  o2,
  output logic [WIDTH-1:0]  o3,
  output logic [CH_NUM-1:0] o_valid,
  input  logic [CH_NUM-1:0] o_ready,
  output logic [CNT_W-1:0]  beat_cnt
);

  sel_t              sel;
  logic              accept;
  logic [CH_NUM-1:0] load;
  logic [CH_NUM-1:0] full;
  logic [WIDTH-1:0]  data [CH_NUM];
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

`ifdef DEMUX14_AUTO_SEL_EN
  sel_t rr_q, rr_d;

  // Advances only on accepted beats, so a stalled channel holds the whole stream.
  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = rr_q + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= CH0;
    else     rr_q <= rr_d;
  end

  assign sel = rr_q;
`else
  assign sel = {s1, s0};
`endif

  assign in_ready = ~full[sel] | o_ready[sel];
  assign accept   = in_valid & in_ready;

  always_comb begin
    load       = '0;
    load[sel]  = accept;
    beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, accept};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_cnt_q <= '0;
    else     beat_cnt_q <= beat_cnt_d;
  end

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_slot
      demux14_slot #(.WIDTH(WIDTH)) u_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (load[gi]),
        .in_data (in_data),
        .o_ready (o_ready[gi]),
        .data    (data[gi]),
        .full    (full[gi])
      );
    end
  endgenerate

  assign o0       = data[CH0];
  assign o1       = data[CH1];
  assign o2       = data[CH2];
  assign o3       = data[CH3];
  assign o_valid  = full;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_demux14_buf.sv
// Directed, table-driven bench for demux14_buf (default select mode or round-robin mode).
module tb_demux14_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        s0, s1;
  logic [7:0]  o0, o1, o2, o3;
  logic [3:0]  o_valid;
  logic [3:0]  o_ready;
  logic [15:0] beat_cnt;

  int tests = 0;
  int fails = 0;

  demux14_buf #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s0       (s0),
    .s1       (s1),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_valid;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] get_o(input int k);
    case (k)
      0:       return o0;
      1:       return o1;
      2:       return o2;
      default: return o3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{2'b00, 8'h11, 4'b1111, 1'b1, 4'b0001, 16'd1};
    vecs[1] = '{2'b01, 8'h22, 4'b1111, 1'b1, 4'b0010, 16'd2};
    vecs[2] = '{2'b10, 8'h33, 4'b1111, 1'b1, 4'b0100, 16'd3};
    vecs[3] = '{2'b11, 8'h44, 4'b1111, 1'b1, 4'b1000, 16'd4};

    rst = 1'b1; in_data = '0; in_valid = 1'b0; s0 = 1'b0; s1 = 1'b0; o_ready = '0;
    #2;
    chk("reset o_valid", o_valid, 4'b0000);
    chk("reset beat_cnt", beat_cnt, 16'h0000);
    chk("reset o0..o3", {o0, o1, o2, o3}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

`ifdef DEMUX14_AUTO_SEL_EN
    // Round-robin: selects are ignored; five beats land on ch0,1,2,3,0.
    s1 = 1'b1; s0 = 1'b1; o_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(i + 1); in_valid = 1'b1;
      #1;
      chk("rr in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("rr o_valid", o_valid, 32'(4'b0001 << (i % 4)));
      chk("rr data", get_o(i % 4), 32'(i + 1));
      $display("[TB] rr beat %0d -> ch%0d data %0h", i, i % 4, get_o(i % 4));
    end
    chk("rr beat_cnt", beat_cnt, 16'd5);
`else
    // Steering sweep.
    for (int i = 0; i < 4; i++) begin
      {s1, s0} = vecs[i].sel; in_data = vecs[i].data; o_ready = vecs[i].ordy; in_valid = 1'b1;
      #1;
      chk("sweep in_ready", in_ready, vecs[i].exp_rdy);
      tick();
      in_valid = 1'b0;
      chk("sweep o_valid", o_valid, vecs[i].exp_valid);
      chk("sweep data", get_o(int'(vecs[i].sel)), vecs[i].data);
      chk("sweep beat_cnt", beat_cnt, vecs[i].exp_cnt);
      $display("[TB] sweep sel %0d data %0h valid %b cnt %0d", vecs[i].sel, vecs[i].data, o_valid, beat_cnt);
    end
    tick();
    chk("drained o_valid", o_valid, 4'b0000);
    chk("held data", {o0, o1, o2, o3}, 32'h11223344);

    // Backpressure on ch1.
    o_ready = 4'b1101; {s1, s0} = 2'b01; in_data = 8'h55; in_valid = 1'b1;
    #1;
    chk("bp first in_ready", in_ready, 1'b1);
    tick();
    chk("bp o1 first", o1, 8'h55);
    chk("bp o_valid", o_valid, 4'b0010);
    in_data = 8'h66;
    #1;
    chk("bp stalled in_ready", in_ready, 1'b0);
    tick();
    chk("bp o1 held", o1, 8'h55);
    chk("bp cnt held", beat_cnt, 16'd5);
    o_ready = 4'b1111;
    #1;
    chk("bp released in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; o_ready = 4'b1101;
    chk("bp o1 second", o1, 8'h66);
    chk("bp o_valid kept", o_valid, 4'b0010);
    chk("bp beat_cnt", beat_cnt, 16'd6);
    $display("[TB] backpressure o1 %0h cnt %0d", o1, beat_cnt);

    // Isolation: ch0 full and stalled, ch3 still accepts.
    o_ready = 4'b1111;
    tick();
    o_ready = 4'b1110; {s1, s0} = 2'b00; in_data = 8'h99; in_valid = 1'b1;
    tick();
    chk("iso ch0 o_valid", o_valid, 4'b0001);
    #1;
    chk("iso ch0 in_ready", in_ready, 1'b0);
    {s1, s0} = 2'b11; in_data = 8'h77;
    #1;
    chk("iso ch3 in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("iso o_valid", o_valid, 4'b1001);
    chk("iso o3", o3, 8'h77);
    chk("iso beat_cnt", beat_cnt, 16'd8);
    $display("[TB] isolation o_valid %b o3 %0h", o_valid, o3);

    // Throughput: one beat per cycle on ch2.
    o_ready = 4'b1111; {s1, s0} = 2'b10; in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 8'(i);
      #1;
      chk("thru in_ready", in_ready, 1'b1);
      tick();
      chk("thru o2", o2, 32'(i));
      chk("thru o_valid2", o_valid[2], 1'b1);
    end
    in_valid = 1'b0;
    chk("thru beat_cnt", beat_cnt, 16'd16);
    $display("[TB] throughput 8 beats cnt %0d", beat_cnt);
`endif

    // Reset asserted between clock edges while a channel holds data.
    o_ready = 4'b0000; {s1, s0} = 2'b10; in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre-rst o_valid nonzero", (o_valid != 4'b0000), 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst o_valid", o_valid, 4'b0000);
    chk("mid rst data", {o0, o1, o2, o3}, 32'h0);
    chk("mid rst beat_cnt", beat_cnt, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post rst in_ready", in_ready, 1'b1);
    $display("[TB] mid-traffic reset done");

    // Counter wrap.
    o_ready = 4'b1111; in_data = 8'h5A; in_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap pre", beat_cnt, 16'hFFFF);
    tick();
    in_valid = 1'b0;
    chk("wrap", beat_cnt, 16'h0000);
    $display("[TB] wrap beat_cnt %0h", beat_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
